// File: rtl/writeback_queue_pkg.sv
// Shared widths and the {rd, data} write-back entry used by execute, memory
// and the write-back queue.
package writeback_queue_pkg;

  localparam int DEF_REG_NUM_BITWIDTH = 5;
  localparam int DEF_WORD_BITWIDTH    = 32;
  localparam int DEF_DEPTH            = 4;

  typedef struct packed {
    logic [DEF_REG_NUM_BITWIDTH-1:0] rd;
    logic [DEF_WORD_BITWIDTH-1:0]    data;
  } wb_entry_t;

endpackage : writeback_queue_pkg

// File: rtl/writeback_queue_match.sv
// Busy lookup: flags a query register that has a write outstanding in any
// valid queue entry. Register 0 is never busy.
module wbq_match #(
  parameter int RW    = 5,
  parameter int DEPTH = 4
) (
  input  logic [RW-1:0]    query_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [RW-1:0]    rd_i [DEPTH],
  output logic             busy_o
);

  logic hit;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (rd_i[i] == query_i)) hit = 1'b1;
    end
    busy_o = hit && (query_i != '0);
  end

endmodule : wbq_match

// File: rtl/writeback_queue.sv
// In-order write-back queue between execute/memory and the register file
// write port, with a two-port busy lookup for decode.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = DEF_REG_NUM_BITWIDTH,
  parameter int WORD_BITWIDTH    = DEF_WORD_BITWIDTH,
  parameter int DEPTH            = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] alu_rd,
  input  logic [WORD_BITWIDTH-1:0]    alu_data,
  output logic                        alu_ready,
  input  logic                        ld_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] ld_rd,
  input  logic [WORD_BITWIDTH-1:0]    ld_data,
  output logic                        ld_ready,
  input  logic                        hold,
  input  logic [REG_NUM_BITWIDTH-1:0] query1,
  input  logic [REG_NUM_BITWIDTH-1:0] query2,
  output logic                        busy1,
  output logic                        busy2,
  output logic [REG_NUM_BITWIDTH-1:0] regToWrite,
  output logic [WORD_BITWIDTH-1:0]    write_data,
  output logic                        doRegWrite
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_NUM_BITWIDTH-1:0] rd_q   [DEPTH];
  logic [WORD_BITWIDTH-1:0]    data_q [DEPTH];
  logic [PW-1:0]               head_q, head_d;
  logic [PW-1:0]               tail_q, tail_d;
  logic [CW-1:0]               count_q, count_d;

  logic                        full;
  logic                        take_ld, take_alu;
  logic                        push, pop;
  logic [REG_NUM_BITWIDTH-1:0] acc_rd;
  logic [WORD_BITWIDTH-1:0]    acc_data;
  logic [DEPTH-1:0]            entry_valid;

  // Handshake: a request transfers on a rising edge where valid && ready.
  // Ready is a function of occupancy only (never of hold or a same-cycle
  // drain); load outranks ALU, so ALU ready also drops whenever ld_valid is up.
  assign full      = (count_q == CW'(DEPTH));
  assign ld_ready  = !rst && !full;
  assign alu_ready = !rst && !full && !ld_valid;

  assign take_ld  = ld_valid && ld_ready;
  assign take_alu = alu_valid && alu_ready;
  assign acc_rd   = take_ld ? ld_rd   : alu_rd;
  assign acc_data = take_ld ? ld_data : alu_data;

  // Writes to x0 complete the handshake but never occupy an entry.
  assign push = (take_ld || take_alu) && (acc_rd != '0);
  assign pop  = !rst && (count_q != '0) && !hold;

  assign doRegWrite = pop;
  assign regToWrite = rd_q[head_q];
  assign write_data = data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= acc_rd;
      data_q[tail_q] <= acc_data;
    end
  end

  // An entry is live when its distance from head is below count.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = !rst && (CW'(PW'(PW'(i) - head_q)) < count_q);
    end
  end

  wbq_match #(.RW(REG_NUM_BITWIDTH), .DEPTH(DEPTH)) u_match1 (
    .query_i (query1),
    .valid_i (entry_valid),
    .rd_i    (rd_q),
    .busy_o  (busy1)
  );

  wbq_match #(.RW(REG_NUM_BITWIDTH), .DEPTH(DEPTH)) u_match2 (
    .query_i (query2),
    .valid_i (entry_valid),
    .rd_i    (rd_q),
    .busy_o  (busy2)
  );

endmodule : writeback_queue

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: linear steps with hand-computed
// expectations plus an in-order write scoreboard.
module tb_writeback_queue;

  localparam int RW = 5;
  localparam int DW = 32;
  localparam int W  = RW + DW;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic [RW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          ld_valid;
  logic [RW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          hold;
  logic [RW-1:0] query1;
  logic [RW-1:0] query2;
  logic          busy1;
  logic          busy2;
  logic [RW-1:0] regToWrite;
  logic [DW-1:0] write_data;
  logic          doRegWrite;

  int n_checks = 0;
  int n_bad    = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  writeback_queue dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .hold       (hold),
    .query1     (query1),
    .query2     (query2),
    .busy1      (busy1),
    .busy2      (busy2),
    .regToWrite (regToWrite),
    .write_data (write_data),
    .doRegWrite (doRegWrite)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write-port beat must match the oldest expected write.
  always @(negedge clk) begin
    if (doRegWrite === 1'b1) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL spurious_write: got rd=%0d data=%0h expected no write", regToWrite, write_data);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        n_checks++;
        assert ({regToWrite, write_data} === mon_exp) else begin
          n_bad++;
          $error("FAIL write_order: got rd=%0d data=%0h expected rd=%0d data=%0h",
                 regToWrite, write_data, mon_exp[W-1:DW], mon_exp[DW-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_alu(input logic v, input logic [RW-1:0] rd, input logic [DW-1:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_ld(input logic v, input logic [RW-1:0] rd, input logic [DW-1:0] d);
    ld_valid = v;
    ld_rd    = rd;
    ld_data  = d;
  endtask

  task automatic expect_write(input logic [RW-1:0] rd, input logic [DW-1:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    hold  = 1'b0;
    query1 = '0;
    query2 = '0;
    drive_alu(1'b0, '0, '0);
    drive_ld(1'b0, '0, '0);

    // Reset state
    tick();
    tick();
    settle();
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_dowrite", 32'(doRegWrite), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    check("post_rst_ld_ready", 32'(ld_ready), 32'd1);

    // Single write, minimum latency
    tick();
    drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    query1 = 5'd5;
    expect_write(5'd5, 32'hDEAD_BEEF);
    settle();
    check("single_ready", 32'(alu_ready), 32'd1);
    check("single_busy_not_yet", 32'(busy1), 32'd0);
    check("single_no_write_yet", 32'(doRegWrite), 32'd0);
    tick();
    drive_alu(1'b0, '0, '0);
    settle();
    check("single_dowrite", 32'(doRegWrite), 32'd1);
    check("single_rd", 32'(regToWrite), 32'd5);
    check("single_data", write_data, 32'hDEAD_BEEF);
    check("single_busy_draining", 32'(busy1), 32'd1);
    tick();
    settle();
    check("single_idle", 32'(doRegWrite), 32'd0);
    check("single_busy_clear", 32'(busy1), 32'd0);

    // Load outranks ALU
    tick();
    drive_ld(1'b1, 5'd3, 32'h33);
    drive_alu(1'b1, 5'd4, 32'h44);
    expect_write(5'd3, 32'h33);
    settle();
    check("prio_ld_ready", 32'(ld_ready), 32'd1);
    check("prio_alu_blocked", 32'(alu_ready), 32'd0);
    tick();
    drive_ld(1'b0, '0, '0);
    expect_write(5'd4, 32'h44);
    settle();
    check("prio_alu_ready", 32'(alu_ready), 32'd1);
    check("prio_first_rd", 32'(regToWrite), 32'd3);
    tick();
    drive_alu(1'b0, '0, '0);
    settle();
    check("prio_second_rd", 32'(regToWrite), 32'd4);
    check("prio_second_we", 32'(doRegWrite), 32'd1);
    tick();
    settle();
    check("prio_idle", 32'(doRegWrite), 32'd0);

    // Fill under hold, then drain in order
    tick();
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_alu(1'b1, RW'(i), 32'h100 + 32'(i));
      expect_write(RW'(i), 32'h100 + 32'(i));
      settle();
      check("fill_alu_ready", 32'(alu_ready), 32'd1);
      tick();
    end
    drive_alu(1'b0, '0, '0);
    drive_ld(1'b1, 5'd9, 32'h99);
    query1 = 5'd4;
    query2 = 5'd2;
    settle();
    check("full_ld_ready", 32'(ld_ready), 32'd0);
    check("full_alu_ready", 32'(alu_ready), 32'd0);
    check("full_hold_no_write", 32'(doRegWrite), 32'd0);
    check("full_busy1", 32'(busy1), 32'd1);
    check("full_busy2", 32'(busy2), 32'd1);
    tick();
    settle();
    check("full_stall_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    hold = 1'b0;
    settle();
    check("drain_first_we", 32'(doRegWrite), 32'd1);
    check("drain_first_rd", 32'(regToWrite), 32'd1);
    check("drain_ready_still_low", 32'(ld_ready), 32'd0);
    tick();
    expect_write(5'd9, 32'h99);
    settle();
    check("drain_ready_back", 32'(ld_ready), 32'd1);
    check("drain_second_rd", 32'(regToWrite), 32'd2);
    tick();
    drive_ld(1'b0, '0, '0);
    tick();
    tick();
    tick();
    settle();
    check("drain_done", 32'(doRegWrite), 32'd0);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // x0 request is consumed without a write
    tick();
    drive_alu(1'b1, 5'd0, 32'h1234);
    query1 = 5'd0;
    query2 = 5'd0;
    settle();
    check("x0_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    drive_alu(1'b0, '0, '0);
    settle();
    check("x0_no_write", 32'(doRegWrite), 32'd0);
    check("x0_busy1", 32'(busy1), 32'd0);
    tick();
    settle();
    check("x0_still_idle", 32'(doRegWrite), 32'd0);

    // Same-register ordering
    tick();
    drive_alu(1'b1, 5'd7, 32'h11);
    expect_write(5'd7, 32'h11);
    tick();
    drive_alu(1'b1, 5'd7, 32'h22);
    expect_write(5'd7, 32'h22);
    query1 = 5'd7;
    settle();
    check("same_busy_first", 32'(busy1), 32'd1);
    check("same_first_data", write_data, 32'h11);
    tick();
    drive_alu(1'b0, '0, '0);
    settle();
    check("same_busy_second", 32'(busy1), 32'd1);
    check("same_second_data", write_data, 32'h22);
    check("same_second_we", 32'(doRegWrite), 32'd1);
    tick();
    settle();
    check("same_busy_clear", 32'(busy1), 32'd0);
    check("same_idle", 32'(doRegWrite), 32'd0);

    // Reset with entries queued discards them
    tick();
    hold = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      drive_alu(1'b1, RW'(i), 32'h200 + 32'(i));
      tick();
    end
    drive_alu(1'b0, '0, '0);
    query1 = 5'd10;
    query2 = 5'd12;
    settle();
    check("mid_busy1", 32'(busy1), 32'd1);
    check("mid_busy2", 32'(busy2), 32'd1);
    check("mid_hold_no_write", 32'(doRegWrite), 32'd0);
    tick();
    rst  = 1'b1;
    hold = 1'b0;
    settle();
    check("mid_rst_no_write", 32'(doRegWrite), 32'd0);
    check("mid_rst_busy1", 32'(busy1), 32'd0);
    check("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("after_rst_no_write", 32'(doRegWrite), 32'd0);
    check("after_rst_busy1", 32'(busy1), 32'd0);
    check("after_rst_busy2", 32'(busy2), 32'd0);
    check("after_rst_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    drive_alu(1'b1, 5'd13, 32'hABCD);
    expect_write(5'd13, 32'hABCD);
    tick();
    drive_alu(1'b0, '0, '0);
    settle();
    check("after_rst_we", 32'(doRegWrite), 32'd1);
    check("after_rst_rd", 32'(regToWrite), 32'd13);
    tick();
    settle();
    check("after_rst_idle", 32'(doRegWrite), 32'd0);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule : tb_writeback_queue

// File: doc/writeback_queue.md
# writeback_queue

Write-side front end for the pipeline's register file: accepts destination-register results from the ALU and load paths, buffers them in a small in-order queue, and drives the register file's write port (`regToWrite`, `write_data`, `doRegWrite`) at one write per cycle. It also reports whether a queried source register still has a write outstanding, so the decode stage can stall or forward. It sits between execute/memory and the register file.

## Interface
- `REG_NUM_BITWIDTH`, 5, register index width
- `WORD_BITWIDTH`, 32, data word width
- `DEPTH`, 4, queue entries; power of two, at least 2
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `alu_valid`  in  1  ALU result request
- `alu_rd`  in  REG_NUM_BITWIDTH  ALU destination register
- `alu_data`  in  WORD_BITWIDTH  ALU result
- `alu_ready`  out  1  ALU request accepted this cycle when high together with `alu_valid`
- `ld_valid`, `ld_rd`, `ld_data`, `ld_ready`: same as the ALU ports, for the load path
- `hold`  in  1  write port unavailable this cycle; no drain
- `query1`, `query2`  in  REG_NUM_BITWIDTH  source registers to check
- `busy1`, `busy2`  out  1  queried register has a queued write
- `regToWrite`  out  REG_NUM_BITWIDTH  write index to the register file
- `write_data`  out  WORD_BITWIDTH  write data to the register file
- `doRegWrite`  out  1  write enable to the register file

## Operation
- Circular buffer of `DEPTH` entries {rd, data}, with a head pointer, a tail pointer, and `count` (width $clog2(DEPTH)+1, range 0..DEPTH). Pointers wrap modulo `DEPTH`.
- Acceptance:
  - At most one request is accepted per cycle. Load has fixed priority over ALU.
  - `ld_ready = !full`.
  - `alu_ready = !full && !ld_valid`.
  - `full` is `count == DEPTH`. Ready never depends on `hold` or on a same-cycle drain.
- An accepted request with rd == 0 is consumed (handshake completes) but not enqueued. `count` is unchanged.
- Drain:
  - When `count != 0` and `!hold`, the head entry is presented on the write port and popped at the clock edge.
  - `doRegWrite = (count != 0) && !hold`.
  - `regToWrite` and `write_data` always show the head entry. They are don't-care when `count == 0`.
- Enqueue and drain in the same cycle: `count` is unchanged and both pointers advance. This is legal at `count == DEPTH`, but ready is still low in that cycle.
- Order: entries drain strictly in acceptance order. Two queued writes to the same register land in order, so the last one wins.
- Busy query:
  - `busyN = (queryN != 0)` AND any valid entry has rd == queryN.
  - Computed combinationally from the stored entries only. A request accepted in the current cycle is not visible until the next cycle.
  - The head entry that is draining this cycle still counts as busy.

## Timing
- Reset: pointers = 0, `count` = 0, `doRegWrite` = 0, `busy1`/`busy2` = 0, `alu_ready`/`ld_ready` = 0 while `rst` is high. Both readies are 1 in the first cycle after reset.
- Reset mid-operation discards all queued entries with no write-port activity. Entry contents need no reset.
- Latency: a request accepted at edge N is written to the register file at the first edge after N where `hold` is low.
  - Minimum latency is 1 cycle: `doRegWrite` is high during cycle N+1.
- Throughput: one enqueue and one drain per cycle, sustained.
- `hold` held high: the queue fills. After `DEPTH` non-x0 acceptances, both readies are low until the first drain edge.

## Structure
- Shared package holds the default widths (`REG_NUM_BITWIDTH`, `WORD_BITWIDTH`) and an entry struct/typedef {rd, data}, shared with the execute and memory stages.
- One natural sub-module: `wbq_match`, which compares one query against all valid entries and returns busy. It is instantiated twice.
- Arbitration, pointers and count stay in the top module.

## Test plan
- Single write: after reset, ALU {rd=5, data=0xDEADBEEF}, `hold`=0 → next cycle `doRegWrite`=1, `regToWrite`=5, `write_data`=0xDEADBEEF; `busy1`=1 for `query1`=5 in that cycle; idle the cycle after.
- Priority: `ld_valid` and `alu_valid` both high (ld rd=3, alu rd=4) → ld accepted and `alu_ready`=0; alu accepted the next cycle; writes to 3 then 4 on consecutive cycles.
- Full/backpressure: `hold`=1 with 4 accepts (rd 1..4) → both readies low; a 5th request stalls; release `hold` → writes 1,2,3,4 in order, and readies go high after the first drain edge.
- x0 discard: ALU rd=0, data=0x1234 → `alu_ready`=1, no `doRegWrite`, `count` stays 0, `busy1` for `query1`=0 stays 0.
- Same-register ordering: rd=7 with 0x11 then rd=7 with 0x22 → two writes in that order; `busy` for 7 stays 1 until the second write drains.
- Reset mid-flight: `hold`=1 with 3 entries queued, pulse `rst` → no writes afterwards, `busy` all 0, `count`=0, and a new request writes after 1 cycle.
